// File: rtl/pipe_mem_stage_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, timeout load value
// and the word-alignment helper used for the data-memory address.
package pipe_defs;

  localparam logic [0:0]  S_IDLE       = 1'b0;
  localparam logic [0:0]  S_WAIT       = 1'b1;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master)
// and the data memory (slave).
interface pipe_mem_stage_if;
  import pipe_defs::*;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/pipe_mem_stage_timer.sv
// Wait counter for the MEM stage: counts cycles already spent waiting on
// memory and flags the last allowed cycle.
module pipe_mem_timer
  import pipe_defs::*;
#(
  parameter logic [7:0] TC = 8'd254
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt;

  // Clear has priority so the count is always 0 on the first wait cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= 8'd0;
    else if (clr)
      cnt <= 8'd0;
    else if (en)
      cnt <= cnt + 8'd1;
  end

  assign tc = (cnt == TC);

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: issues the data-memory access for the E/M instruction,
// stalls the front end until the memory acknowledges, bounds the wait
// with a sticky timeout error, and holds the MEM/WB register.
//
//   state  | meaning
//   S_IDLE | no access outstanding beyond the current cycle
//   S_WAIT | access issued on an earlier cycle, still waiting for ack
module pipe_mem_stage
  import pipe_defs::*;
#(
  parameter int          MAX_WAIT = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mwreg,
  input  logic                     mm2reg,
  input  logic                     mwmem,
  input  logic [31:0]              malu,
  input  logic [31:0]              mb,
  input  logic [4:0]               mrn,
  pipe_mem_stage_if.master         dmem,
  output logic                     mem_stall,
  output logic                     mem_err,
  output logic                     wwreg,
  output logic                     wm2reg,
  output logic [31:0]              wmo,
  output logic [31:0]              walu,
  output logic [4:0]               wrn
);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       mem_op;
  logic       mem_load;
  logic       in_wait;
  logic       tc;
  logic       timeout;
  logic       ack_v;

  // A store wins when both mm2reg and mwmem are set.
  assign mem_op   = mm2reg | mwmem;
  assign mem_load = mm2reg & ~mwmem;
  assign in_wait  = (state == S_WAIT);
  assign timeout  = in_wait & tc & ~dmem.dmem_ack;

  // Reset gating keeps the bus and the stall quiet while reset is held.
  assign dmem.dmem_req   = ~reset & mem_op & ~timeout;
  assign dmem.dmem_we    = mwmem;
  assign dmem.dmem_addr  = word_align(malu);
  assign dmem.dmem_wdata = mb;
  assign mem_stall       = ~reset & mem_op & ~dmem.dmem_ack & ~timeout;

  // An ack without a request is not an access completion.
  assign ack_v = dmem.dmem_ack & dmem.dmem_req;

  pipe_mem_timer #(
    .TC (8'(MAX_WAIT - 1))
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (~in_wait | dmem.dmem_ack | timeout),
    .en    (in_wait & ~dmem.dmem_ack),
    .tc    (tc)
  );

  // Next-state logic for the two-state wait FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mem_op & ~dmem.dmem_ack) state_nxt = S_WAIT;
      S_WAIT:  if (dmem.dmem_ack | timeout)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Sticky timeout error, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      mem_err <= 1'b0;
    else if (timeout)
      mem_err <= 1'b1;
  end

  // MEM/WB register: bubble while stalled, otherwise capture the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wmo    <= 32'd0;
      walu   <= 32'd0;
      wrn    <= 5'd0;
    end else if (mem_stall) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end else begin
      wwreg  <= mwreg;
      wm2reg <= mm2reg;
      walu   <= malu;
      wrn    <= mrn;
      if (mem_load & ack_v)
        wmo <= dmem.dmem_rdata;
      else if (mem_load & timeout)
        wmo <= ERR_DATA;
      else
        wmo <= 32'd0;
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage with a W-stage scoreboard.
module tb_pipe_mem_stage;
  import pipe_defs::*;

  typedef struct packed {
    logic        wwreg;
    logic        wm2reg;
    logic [31:0] wmo;
    logic [31:0] walu;
    logic [4:0]  wrn;
  } wb_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        mem_stall, mem_err;
  logic        wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;

  int n_cmp = 0;
  int n_err = 0;
  wb_t exp_q[$];

  pipe_mem_stage_if dmem ();

  pipe_mem_stage #(.MAX_WAIT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .mwmem     (mwmem),
    .malu      (malu),
    .mb        (mb),
    .mrn       (mrn),
    .dmem      (dmem.master),
    .mem_stall (mem_stall),
    .mem_err   (mem_err),
    .wwreg     (wwreg),
    .wm2reg    (wm2reg),
    .wmo       (wmo),
    .walu      (walu),
    .wrn       (wrn)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_nop();
    mwreg = 0; mm2reg = 0; mwmem = 0;
    malu = 32'h0; mb = 32'h0; mrn = 5'd0;
    dmem.dmem_ack = 0; dmem.dmem_rdata = 32'h0;
  endtask

  // Drives one E/M instruction, plays the memory with an ack on cycle
  // ack_at (negative = never), then checks stall count and W-stage result.
  task automatic do_op(input string tag, input logic i_wreg, input logic i_m2reg,
                       input logic i_wmem, input logic [31:0] i_alu,
                       input logic [31:0] i_b, input logic [4:0] i_rn,
                       input int ack_at, input logic [31:0] rdata,
                       input int exp_stall);
    wb_t e, got;
    logic op, ld;
    int stalls = 0;
    int acks = 0;
    bit done = 0;
    op = i_m2reg | i_wmem;
    ld = i_m2reg & ~i_wmem;
    e.wwreg  = i_wreg;
    e.wm2reg = i_m2reg;
    e.wmo    = ld ? ((op && ack_at < 0) ? 32'hDEADBEEF : rdata) : 32'h0;
    e.walu   = i_alu;
    e.wrn    = i_rn;
    exp_q.push_back(e);
    mwreg = i_wreg; mm2reg = i_m2reg; mwmem = i_wmem;
    malu = i_alu; mb = i_b; mrn = i_rn;
    for (int c = 0; c < 20 && !done; c++) begin
      dmem.dmem_ack   = (c == ack_at);
      dmem.dmem_rdata = (c == ack_at) ? rdata : 32'h0BAD0BAD;
      @(negedge clock);
      if (c == 0) begin
        chk({tag, "_req"}, dmem.dmem_req, op);
        if (op) begin
          chk({tag, "_addr"}, dmem.dmem_addr, {i_alu[31:2], 2'b00});
          chk({tag, "_we"}, dmem.dmem_we, i_wmem);
          chk({tag, "_wdata"}, dmem.dmem_wdata, i_b);
        end
      end
      if (dmem.dmem_req && dmem.dmem_ack) acks++;
      if (c >= 1 && mem_stall) chk({tag, "_bubble"}, wwreg, 1'b0);
      if (mem_stall) stalls++;
      else done = 1;
      @(posedge clock); #1;
    end
    chk({tag, "_bound"}, done, 1'b1);
    chk({tag, "_stalls"}, stalls, exp_stall);
    chk({tag, "_acks"}, acks, (op && ack_at >= 0) ? 1 : 0);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      got = '{wwreg, wm2reg, wmo, walu, wrn};
      chk({tag, "_wwreg"}, got.wwreg, e.wwreg);
      chk({tag, "_wm2reg"}, got.wm2reg, e.wm2reg);
      chk({tag, "_wmo"}, got.wmo, e.wmo);
      chk({tag, "_walu"}, got.walu, e.walu);
      chk({tag, "_wrn"}, got.wrn, e.wrn);
    end
    set_nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    set_nop();
    #12;
    chk("rst_req", dmem.dmem_req, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    chk("rst_wwreg", wwreg, 1'b0);
    chk("rst_wmo", wmo, 32'h0);
    chk("rst_wrn", wrn, 5'd0);
    @(negedge clock); reset = 0;
    @(posedge clock); #1;

    // 1: zero-wait load
    do_op("t1_load", 1, 1, 0, 32'h10, 32'h0, 5'd5, 0, 32'hCAFE0001, 0);
    // 2: store acked after 3 wait cycles
    do_op("t2_store", 0, 0, 1, 32'h23, 32'h55, 5'd2, 3, 32'h0, 3);
    // 3: hung load times out, then a normal load
    do_op("t3_tmo", 1, 1, 0, 32'h100, 32'h0, 5'd7, -1, 32'h0, 4);
    chk("t3_err", mem_err, 1'b1);
    do_op("t3_after", 1, 1, 0, 32'h104, 32'h0, 5'd8, 0, 32'h12345678, 0);
    chk("t3_err_sticky", mem_err, 1'b1);
    // 4: ALU op with a stray ack
    do_op("t4_alu", 1, 0, 0, 32'h7, 32'h0, 5'd3, 0, 32'hFFFFFFFF, 0);
    // 5: back-to-back load then store, one wait each
    do_op("t5_load", 1, 1, 0, 32'h200, 32'h0, 5'd10, 1, 32'hA5A5A5A5, 1);
    do_op("t5_store", 0, 0, 1, 32'h206, 32'h77, 5'd11, 1, 32'h0, 1);
    // both flags set: treated as a store, wm2reg still follows mm2reg
    do_op("t5_both", 0, 1, 1, 32'h300, 32'h99, 5'd12, 0, 32'hCCCCCCCC, 0);

    // 6: reset on the second WAIT cycle of a load
    mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h40; mrn = 5'd9;
    @(negedge clock);
    chk("t6_stall0", mem_stall, 1'b1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t6_stall1", mem_stall, 1'b1);
    @(posedge clock); #3;
    reset = 1;
    #1;
    chk("t6_req", dmem.dmem_req, 1'b0);
    chk("t6_stall", mem_stall, 1'b0);
    chk("t6_err", mem_err, 1'b0);
    chk("t6_wwreg", wwreg, 1'b0);
    chk("t6_wm2reg", wm2reg, 1'b0);
    chk("t6_wmo", wmo, 32'h0);
    chk("t6_walu", walu, 32'h0);
    chk("t6_wrn", wrn, 5'd0);
    set_nop();
    @(negedge clock); reset = 0;
    @(posedge clock); #1;
    do_op("t6_replay", 1, 1, 0, 32'h40, 32'h0, 5'd9, 2, 32'h600DF00D, 2);
    chk("t6_err_after", mem_err, 1'b0);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
